// File: rtl/pc_sequencer.sv
// pc_sequencer: owns the program counter and the per-stage PC/valid pipeline of the
// 5-stage core (F, D, E, M, W). Sequences fetch with load-use stalls, taken-branch
// redirects from E (two bubbles injected into D and E), and a halt/drain sequence.
//
// Ports:
//   clock, reset            rising-edge clock; synchronous active-high reset
//   stall_D                 load-use hazard: hold F and D, bubble into E
//   redirect_E, target_E    taken branch/jump resolved in E (qualified by valid_E)
//   halt_req                stop fetching and drain the pipeline
//   pc_F..pc_W, valid_F..W  PC and valid bit held by each stage
//   flush_D, flush_E        combinational: stage is being squashed this cycle
//   misalign                1-cycle pulse: accepted redirect target had [1:0] != 0
//   halted                  drain complete
module pc_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0100_0000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        stall_D,
    input  logic        redirect_E,
    input  logic [31:0] target_E,
    input  logic        halt_req,
    output logic [31:0] pc_F,
    output logic [31:0] pc_D,
    output logic [31:0] pc_E,
    output logic [31:0] pc_M,
    output logic [31:0] pc_W,
    output logic        valid_F,
    output logic        valid_D,
    output logic        valid_E,
    output logic        valid_M,
    output logic        valid_W,
    output logic        flush_D,
    output logic        flush_E,
    output logic        misalign,
    output logic        halted
);

    typedef enum logic [1:0] {StBoot, StRun, StDrain, StHalted} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_f_q, pc_f_d, pc_d_q, pc_d_d, pc_e_q, pc_e_d;
    logic [31:0] pc_m_q, pc_m_d, pc_w_q, pc_w_d;
    logic        valid_f_q, valid_f_d, valid_d_q, valid_d_d, valid_e_q, valid_e_d;
    logic        valid_m_q, valid_m_d, valid_w_q, valid_w_d;
    logic        misalign_q, misalign_d, halted_q, halted_d;

    logic active;
    logic take_redirect;
    logic take_stall;

    always_comb begin
        state_d    = state_q;
        pc_f_d     = pc_f_q;
        pc_d_d     = pc_d_q;
        pc_e_d     = pc_e_q;
        pc_m_d     = pc_m_q;
        pc_w_d     = pc_w_q;
        valid_d_d  = valid_d_q;
        valid_e_d  = valid_e_q;
        valid_m_d  = valid_m_q;
        valid_w_d  = valid_w_q;
        misalign_d = 1'b0;

        active        = (state_q == StRun) || (state_q == StDrain);
        // Requests from stages holding bubbles are ignored; redirect beats stall.
        take_redirect = active && redirect_E && valid_e_q;
        take_stall    = active && !take_redirect && stall_D && valid_d_q;

        case (state_q)
            // halt_req seen while booting means RUN is skipped entirely.
            StBoot:   state_d = halt_req ? StDrain : StRun;
            StRun:    if (halt_req) state_d = StDrain;
            StDrain:  if (!(valid_d_q || valid_e_q || valid_m_q || valid_w_q)) state_d = StHalted;
            default:  state_d = StHalted;
        endcase

        if (active) begin
            // M and W always advance: the branch or stalled-behind op retires.
            pc_w_d    = pc_m_q;
            valid_w_d = valid_m_q;
            pc_m_d    = pc_e_q;
            valid_m_d = valid_e_q;
            if (take_redirect) begin
                pc_f_d     = {target_E[31:2], 2'b00};
                pc_d_d     = pc_f_q;
                valid_d_d  = 1'b0;
                pc_e_d     = pc_d_q;
                valid_e_d  = 1'b0;
                misalign_d = |target_E[1:0];
            end else if (take_stall) begin
                pc_e_d    = pc_d_q;
                valid_e_d = 1'b0;
            end else begin
                pc_e_d    = pc_d_q;
                valid_e_d = valid_d_q;
                pc_d_d    = pc_f_q;
                valid_d_d = valid_f_q;
                if (state_q == StRun) pc_f_d = pc_f_q + PC_STEP;
            end
        end

        // Fetch is only ever valid while running; leaving RUN drops F at once.
        valid_f_d = (state_d == StRun);
        halted_d  = (state_d == StHalted);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= StBoot;
            pc_f_q     <= RESET_PC;
            pc_d_q     <= RESET_PC;
            pc_e_q     <= RESET_PC;
            pc_m_q     <= RESET_PC;
            pc_w_q     <= RESET_PC;
            valid_f_q  <= 1'b0;
            valid_d_q  <= 1'b0;
            valid_e_q  <= 1'b0;
            valid_m_q  <= 1'b0;
            valid_w_q  <= 1'b0;
            misalign_q <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_f_q     <= pc_f_d;
            pc_d_q     <= pc_d_d;
            pc_e_q     <= pc_e_d;
            pc_m_q     <= pc_m_d;
            pc_w_q     <= pc_w_d;
            valid_f_q  <= valid_f_d;
            valid_d_q  <= valid_d_d;
            valid_e_q  <= valid_e_d;
            valid_m_q  <= valid_m_d;
            valid_w_q  <= valid_w_d;
            misalign_q <= misalign_d;
            halted_q   <= halted_d;
        end
    end

    assign pc_F     = pc_f_q;
    assign pc_D     = pc_d_q;
    assign pc_E     = pc_e_q;
    assign pc_M     = pc_m_q;
    assign pc_W     = pc_w_q;
    assign valid_F  = valid_f_q;
    assign valid_D  = valid_d_q;
    assign valid_E  = valid_e_q;
    assign valid_M  = valid_m_q;
    assign valid_W  = valid_w_q;
    assign flush_D  = take_redirect;
    assign flush_E  = take_redirect;
    assign misalign = misalign_q;
    assign halted   = halted_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios followed by random stimulus. A driver
// advances a pipeline reference model each cycle and queues the expected outputs; a
// monitor pops one entry per clock and compares it with the DUT.
module tb_pc_sequencer;

    localparam logic [31:0] RESET_PC = 32'h0100_0000;
    localparam logic [31:0] PC_STEP  = 32'd4;
    localparam int M_BOOT = 0, M_RUN = 1, M_DRAIN = 2, M_HALTED = 3;

    logic        clock = 1'b0;
    logic        reset, stall_D, redirect_E, halt_req;
    logic [31:0] target_E;
    logic [31:0] pc_F, pc_D, pc_E, pc_M, pc_W;
    logic        valid_F, valid_D, valid_E, valid_M, valid_W;
    logic        flush_D, flush_E, misalign, halted;

    pc_sequencer #(.RESET_PC(RESET_PC), .PC_STEP(PC_STEP)) dut (
        .clock(clock), .reset(reset), .stall_D(stall_D), .redirect_E(redirect_E),
        .target_E(target_E), .halt_req(halt_req),
        .pc_F(pc_F), .pc_D(pc_D), .pc_E(pc_E), .pc_M(pc_M), .pc_W(pc_W),
        .valid_F(valid_F), .valid_D(valid_D), .valid_E(valid_E), .valid_M(valid_M),
        .valid_W(valid_W), .flush_D(flush_D), .flush_E(flush_E), .misalign(misalign),
        .halted(halted)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [159:0] pcs;
        logic [4:0]   v;
        logic         mis;
        logic         hlt;
        logic [1:0]   fl;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    bit   mon_start = 1'b0;

    // Reference model: stage 0 = F ... stage 4 = W.
    logic [31:0] m_pc [5];
    logic        m_v  [5];
    int          m_mode = M_BOOT;
    logic        m_mis = 1'b0;
    logic        m_hlt = 1'b0;

    task automatic model_step(input logic rst, input logic stl, input logic red,
                              input logic [31:0] tgt, input logic hlt, output logic fl);
        logic [31:0] o_pc [5];
        logic        o_v  [5];
        logic        br, hold, any_old;
        fl = (m_mode == M_RUN || m_mode == M_DRAIN) && red && m_v[2];
        if (rst) begin
            for (int i = 0; i < 5; i++) begin
                m_pc[i] = RESET_PC;
                m_v[i]  = 1'b0;
            end
            m_mode = M_BOOT;
            m_mis  = 1'b0;
            m_hlt  = 1'b0;
            return;
        end
        m_mis = 1'b0;
        if (m_mode == M_BOOT) begin
            m_mode  = hlt ? M_DRAIN : M_RUN;
            m_v[0]  = (m_mode == M_RUN);
        end else if (m_mode != M_HALTED) begin
            o_pc    = m_pc;
            o_v     = m_v;
            br      = red && o_v[2];
            hold    = !br && stl && o_v[1];
            any_old = o_v[1] | o_v[2] | o_v[3] | o_v[4];
            m_pc[4] = o_pc[3]; m_v[4] = o_v[3];
            m_pc[3] = o_pc[2]; m_v[3] = o_v[2];
            if (br) begin
                m_pc[0] = {tgt[31:2], 2'b00};
                m_pc[1] = o_pc[0]; m_v[1] = 1'b0;
                m_pc[2] = o_pc[1]; m_v[2] = 1'b0;
                m_mis   = (tgt[1:0] != 2'b00);
            end else if (hold) begin
                m_pc[2] = o_pc[1]; m_v[2] = 1'b0;
            end else begin
                m_pc[2] = o_pc[1]; m_v[2] = o_v[1];
                m_pc[1] = o_pc[0]; m_v[1] = o_v[0];
                if (m_mode == M_RUN) m_pc[0] = o_pc[0] + PC_STEP;
            end
            if (m_mode == M_RUN && hlt) m_mode = M_DRAIN;
            else if (m_mode == M_DRAIN && !any_old) m_mode = M_HALTED;
            m_v[0] = (m_mode == M_RUN);
        end
        m_hlt = (m_mode == M_HALTED);
    endtask

    task automatic cycle(input logic rst, input logic stl, input logic red,
                         input logic [31:0] tgt, input logic hlt);
        exp_t e;
        logic fl;
        @(negedge clock);
        reset      = rst;
        stall_D    = stl;
        redirect_E = red;
        target_E   = tgt;
        halt_req   = hlt;
        model_step(rst, stl, red, tgt, hlt, fl);
        e.pcs = {m_pc[0], m_pc[1], m_pc[2], m_pc[3], m_pc[4]};
        e.v   = {m_v[0], m_v[1], m_v[2], m_v[3], m_v[4]};
        e.mis = m_mis;
        e.hlt = m_hlt;
        e.fl  = {fl, fl};
        sb_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic check(input string name, input logic [159:0] got, input logic [159:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, got, exp);
        end
    endtask

    initial begin : monitor
        exp_t e;
        logic [1:0] fl_s;
        wait (mon_start);
        forever begin
            @(negedge clock);
            #2;
            fl_s = {flush_D, flush_E};
            @(posedge clock);
            #1;
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                check("flush", {158'b0, fl_s}, {158'b0, e.fl});
                check("pcs", {pc_F, pc_D, pc_E, pc_M, pc_W}, e.pcs);
                check("valids", {155'b0, valid_F, valid_D, valid_E, valid_M, valid_W},
                      {155'b0, e.v});
                check("misalign_halted", {158'b0, misalign, halted}, {158'b0, e.mis, e.hlt});
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : driver
        logic        stl, red, hlt, rst;
        logic [31:0] tgt;
        for (int i = 0; i < 5; i++) begin
            m_pc[i] = RESET_PC;
            m_v[i]  = 1'b0;
        end
        reset = 1'b1; stall_D = 1'b0; redirect_E = 1'b0; target_E = 32'h0; halt_req = 1'b0;
        repeat (2) @(posedge clock);
        mon_start = 1'b1;

        // Boot and free run
        cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        idle(8);
        // Aligned redirect
        cycle(1'b0, 1'b0, 1'b1, 32'h0100_0100, 1'b0);
        idle(4);
        // Two-cycle load-use stall
        cycle(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        idle(4);
        // Stall and misaligned redirect together
        cycle(1'b0, 1'b1, 1'b1, 32'h0100_0102, 1'b0);
        idle(4);
        // Halt with a full pipe, then full drain
        cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        idle(8);
        // Reset mid-drain
        cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        idle(6);
        cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        idle(2);
        cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        idle(6);
        // Halt together with a redirect
        cycle(1'b0, 1'b0, 1'b1, 32'h0200_0000, 1'b1);
        idle(7);
        // Halt during boot
        cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        idle(6);
        // PC wrap
        cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        idle(5);
        cycle(1'b0, 1'b0, 1'b1, 32'hFFFF_FFF8, 1'b0);
        idle(4);

        for (int n = 0; n < 800; n++) begin
            rst = ($urandom_range(0, 99) < 2);
            stl = ($urandom_range(0, 4) == 0);
            red = ($urandom_range(0, 5) == 0);
            hlt = ($urandom_range(0, 39) == 0);
            case ($urandom_range(0, 2))
                0:       tgt = $urandom;
                1:       tgt = 32'hFFFF_FFF0 | ($urandom & 32'hF);
                default: tgt = RESET_PC + ($urandom & 32'hFF);
            endcase
            cycle(rst, stl, red, tgt, hlt);
        end

        repeat (3) @(posedge clock);
        #3;
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending entries expected 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
